holy_axi_lite_ram: RTL and testbench
====================================

HOLY_AXI_LITE_RAM -- requirements
Module: holy_axi_lite_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (power of two, >= 4).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port axi_lite  axi_lite_if.slave  32-bit addr/data, 4-bit strobe  AXI-Lite responder.
REQ-006 SHALL have port slave_state  output  2x state enums (write, read)  debug visibility of both FSMs.

Function
REQ-007 SHALL run independent write and read FSMs, so one write and one read can be in flight concurrently.
REQ-008 Write FSM states SHALL be W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP.
REQ-009 In W_IDLE, awready=1 and wready=1; AW-only handshake -> W_GOT_ADDR; W-only handshake -> W_GOT_DATA; both in the same cycle -> commit and go to W_RESP.
REQ-010 In W_GOT_ADDR only wready=1 and in W_GOT_DATA only awready=1; the completing handshake commits the write -> W_RESP.
REQ-011 Commit SHALL update only the bytes whose wstrb bit is 1; wstrb=4'b0000 changes nothing but still gets a response.
REQ-012 In W_RESP, bvalid=1 and bresp is held stable until bready=1 -> W_IDLE; awready and wready SHALL be 0 in W_RESP.
REQ-013 bvalid SHALL rise exactly one cycle after the commit cycle.
REQ-014 Read FSM states SHALL be R_IDLE, R_FETCH, R_DATA.
REQ-015 In R_IDLE, arready=1; an AR handshake latches araddr -> R_FETCH; R_FETCH reads memory -> R_DATA.
REQ-016 In R_DATA, rvalid=1 with rdata and rresp held stable until rready=1 -> R_IDLE; arready SHALL be 0 outside R_IDLE.
REQ-017 rvalid SHALL rise exactly two cycles after the AR handshake cycle.
REQ-018 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] is ignored for both reads and writes.
REQ-019 A read fetched in the same cycle as a write commit to the same word SHALL return the pre-write data (read-first).
REQ-020 rresp and bresp SHALL be 2'b00 (OKAY) except as set by REQ-025.

Reset
REQ-021 rst_n low SHALL immediately force W_IDLE and R_IDLE, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-022 While rst_n is low, awready, wready and arready SHALL be 0; all three go to 1 in the first cycle after deassertion.
REQ-023 Reset mid-transaction SHALL drop the transaction with no response; a write that has not committed SHALL NOT modify memory.
REQ-024 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-025 With HOLY_LITE_RAM_ADDR_ERR_EN defined, an address below BASE_ADDR or with index >= DEPTH_WORDS SHALL get SLVERR (2'b10): a write is not committed and a read returns rdata=0.
REQ-026 Without HOLY_LITE_RAM_ADDR_ERR_EN, the index SHALL wrap modulo DEPTH_WORDS and every response SHALL be OKAY.

Structure
REQ-027 The lite_slave_wstate_t and lite_slave_rstate_t enums and the AXI_RESP_OKAY and AXI_RESP_SLVERR constants SHALL live in holy_core_pkg.
REQ-028 Storage SHALL be the sub-module holy_lite_ram_bank: one write port with byte enable, one read port with a registered read, inferable as BRAM.

Verification
REQ-029 Write 0xDEADBEEF, wstrb=4'hF, to BASE+0x10 with AW and W in the same cycle, then read BASE+0x10 -> bvalid 1 cycle after commit, bresp=0; rvalid 2 cycles after AR, rdata=0xDEADBEEF.
REQ-030 W before AW: W data 0x11223344, strb=4'b0101, to a word holding 0xAAAAAAAA -> W_GOT_DATA, then W_RESP; readback 0xAA22AA44.
REQ-031 Hold bready=0 and rready=0 for 5 cycles -> bvalid, rvalid and the response values stay stable; awready, wready and arready stay 0.
REQ-032 AR to word X accepted in the same cycle the write to X commits (old 0x0, new 0x5) -> read returns 0x0; the next read returns 0x5.
REQ-033 With the macro defined, write/read BASE+DEPTH_WORDS*4 -> bresp=2'b10, rresp=2'b10, rdata=0, memory unchanged; without the macro, word 0 is accessed with OKAY.
REQ-034 Assert rst_n low in W_GOT_ADDR and in R_FETCH -> bvalid and rvalid stay 0, target word unchanged, ready signals return 1 after release.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared AXI-Lite slave types: FSM state enums, debug state bundle and response codes.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the lite RAM and any other AXI-Lite responders.
package holy_core_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_ADDR,
    W_GOT_DATA,
    W_RESP
  } lite_slave_wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } lite_slave_rstate_t;

  typedef struct packed {
    lite_slave_wstate_t w;
    lite_slave_rstate_t r;
  } lite_slave_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle: 32-bit address/data, 4-bit write strobe, one modport per side.
// Wires only; latency and backpressure are owned by the endpoints.
// Standard valid/ready on all five channels.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/holy_lite_ram_bank.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port (BRAM style).
// Read latency 1 cycle; a same-cycle write to the read word returns the old data.
// No backpressure; the read register holds its value while re is low.
module holy_lite_ram_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/holy_axi_lite_ram.sv
// AXI-Lite RAM with independent write/read FSMs; HOLY_LITE_RAM_ADDR_ERR_EN adds SLVERR on out-of-range addresses.
// Latency: bvalid 1 cycle after write commit, rvalid 2 cycles after AR handshake.
// Backpressure: one transaction per channel in flight; responses held until bready/rready.
module holy_axi_lite_ram
  import holy_core_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_lite_if.slave         axi_lite,
  output lite_slave_state_t slave_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  lite_slave_wstate_t wstate, wstate_nxt;
  lite_slave_rstate_t rstate, rstate_nxt;

  logic        rdy_en;
  logic [31:0] awaddr_q, wdata_q, rdata_q, bank_rdata;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        r_err_q;
  logic        aw_hs, w_hs, ar_hs, commit, w_err, ar_err;
  logic [31:0] w_addr_sel, w_dat_sel, w_off, r_off;
  logic [3:0]  w_strb_sel;
  logic        unused_off;

  assign axi_lite.awready = rdy_en && (wstate == W_IDLE || wstate == W_GOT_DATA);
  assign axi_lite.wready  = rdy_en && (wstate == W_IDLE || wstate == W_GOT_ADDR);
  assign axi_lite.arready = rdy_en && (rstate == R_IDLE);
  assign axi_lite.bvalid  = (wstate == W_RESP);
  assign axi_lite.bresp   = bresp_q;
  assign axi_lite.rvalid  = (rstate == R_DATA);
  assign axi_lite.rresp   = rresp_q;
  assign axi_lite.rdata   = rdata_q;
  assign slave_state      = '{w: wstate, r: rstate};

  assign aw_hs = axi_lite.awvalid && axi_lite.awready;
  assign w_hs  = axi_lite.wvalid  && axi_lite.wready;
  assign ar_hs = axi_lite.arvalid && axi_lite.arready;

  // Whichever half arrived first is taken from its latch, the completing half from the bus.
  assign w_addr_sel = (wstate == W_GOT_ADDR) ? awaddr_q : axi_lite.awaddr;
  assign w_dat_sel  = (wstate == W_GOT_DATA) ? wdata_q  : axi_lite.wdata;
  assign w_strb_sel = (wstate == W_GOT_DATA) ? wstrb_q  : axi_lite.wstrb;
  assign w_off      = w_addr_sel - BASE_ADDR;
  assign r_off      = axi_lite.araddr - BASE_ADDR;
  assign unused_off = ^{w_off[1:0], w_off[31:AW+2], r_off[1:0], r_off[31:AW+2]};

`ifdef HOLY_LITE_RAM_ADDR_ERR_EN
  assign w_err  = (w_addr_sel < BASE_ADDR) || (|w_off[31:AW+2]);
  assign ar_err = (axi_lite.araddr < BASE_ADDR) || (|r_off[31:AW+2]);
`else
  assign w_err  = 1'b0;
  assign ar_err = 1'b0;
`endif

  always_comb begin
    wstate_nxt = wstate;
    commit     = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end else if (aw_hs) begin
          wstate_nxt = W_GOT_ADDR;
        end else if (w_hs) begin
          wstate_nxt = W_GOT_DATA;
        end
      end
      W_GOT_ADDR: if (w_hs) begin
        commit     = 1'b1;
        wstate_nxt = W_RESP;
      end
      W_GOT_DATA: if (aw_hs) begin
        commit     = 1'b1;
        wstate_nxt = W_RESP;
      end
      W_RESP:  if (axi_lite.bready) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // The bank read is issued on the AR handshake edge, so R_FETCH only moves it to the output register.
  always_comb begin
    rstate_nxt = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_FETCH;
      R_FETCH: rstate_nxt = R_DATA;
      R_DATA:  if (axi_lite.rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate   <= W_IDLE;
      rstate   <= R_IDLE;
      rdy_en   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= AXI_RESP_OKAY;
      rresp_q  <= AXI_RESP_OKAY;
      rdata_q  <= '0;
      r_err_q  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      wstate <= wstate_nxt;
      rstate <= rstate_nxt;
      if (aw_hs) awaddr_q <= axi_lite.awaddr;
      if (w_hs) begin
        wdata_q <= axi_lite.wdata;
        wstrb_q <= axi_lite.wstrb;
      end
      if (commit) bresp_q <= w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      if (ar_hs) r_err_q <= ar_err;
      if (rstate == R_FETCH) begin
        rresp_q <= r_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rdata_q <= r_err_q ? 32'h0 : bank_rdata;
      end
    end
  end

  holy_lite_ram_bank #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (commit && !w_err),
    .waddr (w_off[AW+1:2]),
    .wdata (w_dat_sel),
    .wbe   (w_strb_sel),
    .re    (ar_hs),
    .raddr (r_off[AW+1:2]),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_holy_axi_lite_ram.sv
// Directed bench for holy_axi_lite_ram (DEPTH_WORDS=16, BASE_ADDR=0x1000).
module tb_holy_axi_lite_ram;
  import holy_core_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  lite_slave_state_t st;
  int                n_checks = 0;
  int                n_fail = 0;

  axi_lite_if bus();

  holy_axi_lite_ram #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_lite    (bus),
    .slave_state (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    check({tag, " bvalid_pre"}, 32'(bus.bvalid), 32'h0);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check({tag, " bvalid"}, 32'(bus.bvalid), 32'h1);
    check({tag, " bresp"}, 32'(bus.bresp), 32'(exp_resp));
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    check({tag, " arready"}, 32'(bus.arready), 32'h1);
    tick();
    bus.arvalid = 1'b0;
    check({tag, " rvalid_fetch"}, 32'(bus.rvalid), 32'h0);
    tick();
    check({tag, " rvalid"}, 32'(bus.rvalid), 32'h1);
    check({tag, " rdata"}, bus.rdata, exp_data);
    check({tag, " rresp"}, 32'(bus.rresp), 32'(exp_resp));
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst awready", 32'(bus.awready), 32'h0);
    check("rst wready", 32'(bus.wready), 32'h0);
    check("rst arready", 32'(bus.arready), 32'h0);
    check("rst bvalid", 32'(bus.bvalid), 32'h0);
    check("rst rvalid", 32'(bus.rvalid), 32'h0);
    check("rst rdata", bus.rdata, 32'h0);
    check("rst wstate", 32'(st.w), 32'(W_IDLE));
    check("rst rstate", 32'(st.r), 32'(R_IDLE));
    rst_n = 1'b1;
    tick();
    check("post_rst awready", 32'(bus.awready), 32'h1);
    check("post_rst wready", 32'(bus.wready), 32'h1);
    check("post_rst arready", 32'(bus.arready), 32'h1);

    // AW and W together, then read back
    do_write("wr_beef", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, AXI_RESP_OKAY);
    do_read("rd_beef", BASE + 32'h10, 32'hDEAD_BEEF, AXI_RESP_OKAY);
    do_read("rd_beef_unal", BASE + 32'h13, 32'hDEAD_BEEF, AXI_RESP_OKAY);

    // W before AW with partial strobe
    do_write("wr_aaaa", BASE + 32'h20, 32'hAAAA_AAAA, 4'hF, AXI_RESP_OKAY);
    bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("wfirst state", 32'(st.w), 32'(W_GOT_DATA));
    check("wfirst awready", 32'(bus.awready), 32'h1);
    check("wfirst wready", 32'(bus.wready), 32'h0);
    check("wfirst bvalid", 32'(bus.bvalid), 32'h0);
    bus.wdata = 32'hFFFF_FFFF;
    bus.awaddr = BASE + 32'h22; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("wfirst resp_state", 32'(st.w), 32'(W_RESP));
    check("wfirst bvalid1", 32'(bus.bvalid), 32'h1);
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    do_read("rd_strb", BASE + 32'h20, 32'hAA22_AA44, AXI_RESP_OKAY);

    // AW before W
    bus.awaddr = BASE + 32'h24; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.awaddr = BASE + 32'h3C;
    check("afirst state", 32'(st.w), 32'(W_GOT_ADDR));
    check("afirst awready", 32'(bus.awready), 32'h0);
    check("afirst wready", 32'(bus.wready), 32'h1);
    bus.wdata = 32'h0BAD_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("afirst bvalid", 32'(bus.bvalid), 32'h1);
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    do_read("rd_afirst", BASE + 32'h24, 32'h0BAD_F00D, AXI_RESP_OKAY);

    // Zero strobe: response but no change
    do_write("wr_strb0", BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, AXI_RESP_OKAY);
    do_read("rd_strb0", BASE + 32'h10, 32'hDEAD_BEEF, AXI_RESP_OKAY);

    // Concurrent write and read with both responses stalled
    bus.awaddr = BASE + 32'h14; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("conc bvalid", 32'(bus.bvalid), 32'h1);
    check("conc rvalid_fetch", 32'(bus.rvalid), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall bvalid", 32'(bus.bvalid), 32'h1);
      check("stall rvalid", 32'(bus.rvalid), 32'h1);
      check("stall rdata", bus.rdata, 32'hDEAD_BEEF);
      check("stall bresp", 32'(bus.bresp), 32'h0);
      check("stall rresp", 32'(bus.rresp), 32'h0);
      check("stall awready", 32'(bus.awready), 32'h0);
      check("stall wready", 32'(bus.wready), 32'h0);
      check("stall arready", 32'(bus.arready), 32'h0);
      tick();
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("conc bvalid_done", 32'(bus.bvalid), 32'h0);
    check("conc rvalid_done", 32'(bus.rvalid), 32'h0);
    do_read("rd_conc", BASE + 32'h14, 32'h1234_5678, AXI_RESP_OKAY);

    // Read-first collision
    do_write("wr_zero", BASE + 32'h08, 32'h0, 4'hF, AXI_RESP_OKAY);
    bus.awaddr = BASE + 32'h08; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = BASE + 32'h08; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("coll bvalid", 32'(bus.bvalid), 32'h1);
    tick();
    check("coll rvalid", 32'(bus.rvalid), 32'h1);
    check("coll rdata_old", bus.rdata, 32'h0);
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read("coll rdata_new", BASE + 32'h08, 32'h5, AXI_RESP_OKAY);

    // Out-of-range addresses
    do_write("wr_w0", BASE, 32'h0101_0101, 4'hF, AXI_RESP_OKAY);
    do_write("wr_w15", BASE + 32'h3C, 32'h0F0F_0F0F, 4'hF, AXI_RESP_OKAY);
`ifdef HOLY_LITE_RAM_ADDR_ERR_EN
    do_write("err wr_hi", BASE + 32'(DEPTH * 4), 32'hCAFE_F00D, 4'hF, AXI_RESP_SLVERR);
    do_read("err rd_hi", BASE + 32'(DEPTH * 4), 32'h0, AXI_RESP_SLVERR);
    do_read("err w0_kept", BASE, 32'h0101_0101, AXI_RESP_OKAY);
    do_read("err rd_lo", BASE - 32'h4, 32'h0, AXI_RESP_SLVERR);
`else
    do_write("wrap wr_hi", BASE + 32'(DEPTH * 4), 32'hCAFE_F00D, 4'hF, AXI_RESP_OKAY);
    do_read("wrap w0", BASE, 32'hCAFE_F00D, AXI_RESP_OKAY);
    do_read("wrap rd_hi", BASE + 32'(DEPTH * 4), 32'hCAFE_F00D, AXI_RESP_OKAY);
    do_read("wrap rd_lo", BASE - 32'h4, 32'h0F0F_0F0F, AXI_RESP_OKAY);
`endif

    // Reset mid-transaction
    do_write("wr_w6", BASE + 32'h18, 32'h6666_6666, 4'hF, AXI_RESP_OKAY);
    bus.awaddr = BASE + 32'h18; bus.awvalid = 1'b1;
    bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    check("mid wstate", 32'(st.w), 32'(W_GOT_ADDR));
    check("mid rstate", 32'(st.r), 32'(R_FETCH));
    bus.wdata = 32'h9999_9999; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst wstate", 32'(st.w), 32'(W_IDLE));
    check("mid_rst rstate", 32'(st.r), 32'(R_IDLE));
    check("mid_rst wready", 32'(bus.wready), 32'h0);
    check("mid_rst awready", 32'(bus.awready), 32'h0);
    check("mid_rst arready", 32'(bus.arready), 32'h0);
    repeat (2) begin
      tick();
      check("mid_rst bvalid", 32'(bus.bvalid), 32'h0);
      check("mid_rst rvalid", 32'(bus.rvalid), 32'h0);
      check("mid_rst rdata", bus.rdata, 32'h0);
    end
    bus.wvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("mid_rel awready", 32'(bus.awready), 32'h1);
    check("mid_rel wready", 32'(bus.wready), 32'h1);
    check("mid_rel arready", 32'(bus.arready), 32'h1);
    check("mid_rel bvalid", 32'(bus.bvalid), 32'h0);
    do_read("mid w6_kept", BASE + 32'h18, 32'h6666_6666, AXI_RESP_OKAY);
    do_read("mid w4_kept", BASE + 32'h10, 32'hDEAD_BEEF, AXI_RESP_OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
